// File: rtl/sample_feeder.sv
// sample_feeder: buffered sample source for the 8-bit averaging filter.
// Upstream samples enter a small FIFO over a valid/ready handshake. Once the
// fill level reaches PRIME, one sample is popped every i_rate+1 cycles into
// the registered o_data output, and an empty pop slot flags a sticky underrun.
// Optional feature macro: SAMPLE_FEEDER_ZERO_FILL_EN. When it is defined,
// o_data is forced to zero after an underrun (silence insertion). When it is
// undefined, the last popped sample is held (zero-order hold).
module sample_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PRIME  = 4,
  parameter int RATE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [RATE_W-1:0]      i_rate,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_strobe,
  output logic                   o_underrun,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_STARVED
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [RATE_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                strobe_q, strobe_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                push;
  logic                pop;

  // Ready depends only on the registered level, never on a same-cycle pop.
  assign o_ready    = (level_q != FULL_LVL);
  assign push       = i_valid && o_ready;

  assign o_data     = data_q;
  assign o_strobe   = strobe_q;
  assign o_underrun = underrun_q;
  assign o_level    = level_q;

  // Sequencer: next state, rate counter, output word and underrun flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below leaves a variable unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    pop        = 1'b0;

    if (!i_enable) begin
      // Disable wins in every state; a tick due this cycle is simply dropped.
      state_d = ST_IDLE;
      data_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_PRIME;
          underrun_d = 1'b0;
        end
        ST_PRIME: begin
          if (level_q >= PRIME_LVL) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            cnt_d = i_rate;
            if (level_q != '0) begin
              pop      = 1'b1;
              data_d   = mem_q[rd_ptr_q];
              strobe_d = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_STARVED;
`ifdef SAMPLE_FEEDER_ZERO_FILL_EN
              data_d     = '0;
`endif
            end
          end else begin
            cnt_d = cnt_q - RATE_W'(1);
          end
        end
        ST_STARVED: begin
          state_d = ST_PRIME;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage written on every accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the level and pointers decide
    // which entries are valid, so clearing the data would add nothing.
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Buffered sample source for the 8-bit averaging filter datapath. Accepts samples from an upstream producer over a valid/ready handshake and stores them in a small FIFO. Once a priming level is reached, it presents one sample on `o_data` every `i_rate+1` clock cycles. The filter consumes `o_data` as its `i_data` on every clock, so the feeder holds each sample steady between updates, detects underrun and signals it.

## Interface
Parameters:
- `DATA_W`, 8: sample width.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `PRIME`, 4: fill level required before output starts; range 1..DEPTH.
- `RATE_W`, 4: width of `i_rate`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  run request.
- `i_rate`  in  RATE_W  output period minus one, in cycles.
- `i_data`  in  DATA_W  upstream sample.
- `i_valid`  in  1  upstream sample valid.
- `o_ready`  out  1  FIFO can accept a sample.
- `o_data`  out  DATA_W  sample presented to the filter; registered.
- `o_strobe`  out  1  one-cycle pulse, high in the cycle `o_data` takes a new popped value.
- `o_underrun`  out  1  sticky underrun flag.
- `o_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: occurs when `i_valid && o_ready`.
- `o_ready` = (level != DEPTH). It does not depend on a same-cycle pop.
- Pop: occurs on a rate tick in RUN when level != 0.
- Simultaneous push and pop leaves level unchanged.
- Pointers wrap modulo DEPTH.

State machine:
- IDLE:
  - `o_data` = 0.
  - FIFO contents are retained, and pushes are still accepted.
  - Goes to PRIME when `i_enable`=1; this transition clears `o_underrun`.
- PRIME:
  - `o_data` holds its value.
  - Goes to RUN when level >= PRIME. On entry to RUN the rate counter is loaded with 0.
- RUN:
  - Rate counter = 0 marks a tick. On a tick: pop, reload the counter with the current `i_rate`, and register the popped word into `o_data` with `o_strobe`=1 next cycle.
  - Otherwise the counter decrements.
  - A tick with level = 0 sets `o_underrun` and goes to STARVED.
- STARVED:
  - Output per the Configuration section.
  - Goes to PRIME on the next cycle.
- `i_enable`=0 in any state: go to IDLE next cycle and force `o_data` to 0. A pop pending in that cycle is dropped.
- `i_rate` changes take effect only at the next reload.
- Reset clears all state: state=IDLE, level=0, pointers=0, counter=0.
  - Reset mid-stream discards buffered samples.

## Timing
Reset values:
- `o_data`=0, `o_strobe`=0, `o_underrun`=0, `o_level`=0.
- `o_ready`=1 in the cycle after reset releases.

Latencies:
- `o_level` updates one cycle after the push or pop.
- Start-up: the push that reaches PRIME is at cycle t. Level >= PRIME is visible at t+1, RUN is entered at t+2, the first pop happens at t+2, and `o_data`/`o_strobe` update at t+3.
- Steady state: successive `o_strobe` pulses are exactly `i_rate+1` cycles apart. With `i_rate`=0, a new sample arrives every cycle.
- Underrun: `o_underrun` rises the cycle after the empty tick.
- Full FIFO: `o_ready` is low in the cycle after level reaches DEPTH and rises the cycle after the next pop.

## Configuration
- `SAMPLE_FEEDER_ZERO_FILL_EN` defined: on underrun, `o_data` is forced to 0 in the cycle after the empty tick and stays 0 until the next strobe. This gives silence insertion.
- Undefined (default): `o_data` holds the last popped sample through STARVED and PRIME (zero-order hold).
- Both builds set `o_underrun` identically; `o_strobe` does not pulse for a filler value.

## Test plan
- Reset and idle: assert `rst` 2 cycles with `i_enable`=0. Requires `o_data`=0, `o_strobe`=0, `o_level`=0, `o_ready`=1.
- Priming and rate: `i_rate`=2, push 10,20,30,40 back-to-back, then `i_enable`=1. Requires strobes 3 cycles apart carrying 10,20,30,40, and the first strobe 3 cycles after level reaches 4.
- Full backpressure: with `i_enable`=0, hold `i_valid`=1 with data 1..9. Requires `o_level`=8 and `o_ready`=0, the 9th word not accepted, and that word accepted one cycle after the first pop.
- Underrun: `i_rate`=0, PRIME=4, push 5,6,7,8 and stop. Requires 4 consecutive strobes, then `o_underrun`=1. `o_data` must stay 8 (default build) or read 0 (`SAMPLE_FEEDER_ZERO_FILL_EN` build). State must return to PRIME, with no strobe until 4 more pushes arrive.
- Mid-stream disable and reset: deassert `i_enable` during RUN with level 3. Requires `o_data`=0 next cycle and `o_level` to stay 3. Then assert `rst` for 1 cycle; requires `o_level`=0 and `o_underrun`=0.
